// File: rtl/sub8_pipe_slices.sv
// sub8_pipe_slices -- pipelined unsigned subtractor, diff = a - b - bin.
//
// The operands are cut into SLICE-bit slices. Each pipeline stage resolves one
// slice and hands its borrow to the next stage. Operand slices are skewed on
// the way in and result slices are de-skewed on the way out, so every slice of
// one operation leaves in the same cycle. Latency is NSTG = WIDTH/SLICE clocks
// and throughput is one operation per clock. There is no backpressure.
//
// Optional build macro:
//   SUB8_PIPE_SAT_EN  when defined, diff is forced to 0 whenever the final
//                     borrow is set (saturating subtract). bout is unaffected.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   a/b/bin qualify this cycle
//   a          minuend (unsigned, WIDTH bits)
//   b          subtrahend (unsigned, WIDTH bits)
//   bin        borrow in
//   out_valid  diff/bout qualify this cycle
//   diff       a - b - bin modulo 2^WIDTH (or saturated to 0, see above)
//   bout       1 when a < b + bin
module sub8_pipe_slices #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NSTG = WIDTH / SLICE;
  // Stages 0..NSTG-2 are registered; the last stage feeds the output register.
  localparam int NREG = (NSTG > 1) ? NSTG - 1 : 1;

  if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
    $error("sub8_pipe_slices: WIDTH must be a non-zero multiple of SLICE");
  end

  logic [SLICE-1:0] a_st   [NSTG];   // operand slice aligned to stage k
  logic [SLICE-1:0] b_st   [NSTG];
  logic             brw_in [NSTG];   // borrow entering stage k
  logic [SLICE:0]   sub_st [NSTG];   // {borrow_out, diff_slice} of stage k
  logic             brw_q  [NREG];   // registered borrow out of stage k
  logic [SLICE-1:0] d_tail [NREG];   // result slice k, one clock before output
  logic [NSTG-1:0]  vld_q;
  logic [WIDTH-1:0] diff_nxt;
  logic             bout_nxt;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg

    if (k == 0) begin : g_head
      assign a_st[k]   = a[SLICE-1:0];
      assign b_st[k]   = b[SLICE-1:0];
      assign brw_in[k] = bin;
    end else begin : g_skew
      // k-deep delay so slice k meets the borrow of its own operation.
      logic [SLICE-1:0] a_sk [k];
      logic [SLICE-1:0] b_sk [k];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < k; i++) begin
            a_sk[i] <= '0;
            b_sk[i] <= '0;
          end
        end else begin
          a_sk[0] <= a[k*SLICE +: SLICE];
          b_sk[0] <= b[k*SLICE +: SLICE];
          for (int i = 1; i < k; i++) begin
            a_sk[i] <= a_sk[i-1];
            b_sk[i] <= b_sk[i-1];
          end
        end
      end

      assign a_st[k]   = a_sk[k-1];
      assign b_st[k]   = b_sk[k-1];
      assign brw_in[k] = brw_q[k-1];
    end

    // Zero-extended SLICE+1 bit subtract; the MSB is the borrow out.
    assign sub_st[k] = {1'b0, a_st[k]} - {1'b0, b_st[k]} - {{SLICE{1'b0}}, brw_in[k]};

    if (k < NSTG - 1) begin : g_reg
      localparam int TAIL = NSTG - 2 - k;
      logic [SLICE-1:0] d_r;
      logic             brw_r;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d_r   <= '0;
          brw_r <= 1'b0;
        end else begin
          d_r   <= sub_st[k][SLICE-1:0];
          brw_r <= sub_st[k][SLICE];
        end
      end

      assign brw_q[k] = brw_r;

      // De-skew: the output register supplies the last delay of every slice.
      if (TAIL == 0) begin : g_notail
        assign d_tail[k] = d_r;
      end else begin : g_tail
        logic [SLICE-1:0] dl [TAIL];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < TAIL; i++) dl[i] <= '0;
          end else begin
            dl[0] <= d_r;
            for (int i = 1; i < TAIL; i++) dl[i] <= dl[i-1];
          end
        end

        assign d_tail[k] = dl[TAIL-1];
      end
    end
  end

  always_comb begin
    diff_nxt = '0;
    for (int k = 0; k < NSTG - 1; k++) diff_nxt[k*SLICE +: SLICE] = d_tail[k];
    diff_nxt[(NSTG-1)*SLICE +: SLICE] = sub_st[NSTG-1][SLICE-1:0];
    bout_nxt = sub_st[NSTG-1][SLICE];
`ifdef SUB8_PIPE_SAT_EN
    if (bout_nxt) diff_nxt = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < NSTG; i++) vld_q[i] <= vld_q[i-1];
      diff <= diff_nxt;
      bout <= bout_nxt;
    end
  end

  assign out_valid = vld_q[NSTG-1];

endmodule
